edge_adder_switch_acc: RTL and testbench
========================================

Name: edge_adder_switch_acc

Overview:
Parametrised successor edge adder switch for the reduction network, integer datapath.
- Adds, forwards or emits VN values, as before.
- New: configurable adder pipeline depth, with every command path delay-matched so all results share one fixed latency.
- New: per-output valid strobes, and a multi-beat accumulate mode (counter + FSM) for VNs larger than one reduction pass.

Parameters:
DATA_TYPE, 16, lane width in bits (two's complement integer)
NUM_IN, 4, lanes on input bus
SEL_IN, 2, width of pair-select
ADD_LAT, 2, adder pipeline stages (>=1); total latency LAT = ADD_LAT+1
CNT_W, 8, width of accumulate length/counter

Ports:
CLK  input  1  clock
rst  input  1  reset, synchronous, active-high
i_valid  input  1  beat valid
i_data_bus  input  DATA_TYPE*NUM_IN  lanes; lane n = bits [n*DATA_TYPE +: DATA_TYPE]
i_cmd  input  3  command, sampled with beat
i_sel  input  SEL_IN  pair select
i_acc_len  input  CNT_W  beats per accumulation; sampled on first 110 beat
o_adder  output  DATA_TYPE  sum/forwarded value
o_adder_valid  output  1  o_adder strobe
o_vn  output  2*DATA_TYPE  VN outputs {high slot, low slot}
o_vn_valid  output  2  per-slot strobe
o_err  output  1  sticky protocol error

Behaviour:
- Reset: all outputs 0, FSM=IDLE, counter 0, all pipeline valids cleared. Reset mid-operation discards all in-flight beats and any partial accumulation.
- Pair mux (combinational): s = min(i_sel, NUM_IN-2); A = lane s+1, B = lane s.
- Beat accepted at edge k when i_valid=1. Stage 0 registers A, B, cmd, lane0 and lane NUM_IN-1. Result outputs change after edge k+LAT, visible for exactly one cycle.
- Strobes are single-cycle pulses. Data outputs hold their last value when not strobed.
- Streaming operation: one beat per cycle, no backpressure.
- i_valid=0 cycles are bubbles that propagate through the pipe.
- Commands:
  - 000/001/111 idle: no strobes.
  - 010 add: o_adder = A+B mod 2^DATA_TYPE; o_adder_valid=1.
  - 011: o_vn low slot = lane0, o_vn_valid=01; o_adder = A, o_adder_valid=1.
  - 100: o_vn high slot = lane NUM_IN-1, o_vn_valid=10; o_adder = B, o_adder_valid=1.
  - 101: o_vn = {A,B}, o_vn_valid=11, no o_adder_valid.
  - 110 accumulate: see FSM below.
- Forward/VN paths run through a (LAT)-deep shift register alongside the adder pipe, so all commands have identical latency.
- FSM, evaluated at pipe output (stage LAT):
  - IDLE, cmd 110 arriving:
    - len = max(i_acc_len captured with that beat, 1).
    - If len==1: emit the sum immediately, stay IDLE.
    - Otherwise: acc = sum, cnt = 1, go to ACC.
  - ACC, cmd 110 arriving:
    - acc += sum; cnt++.
    - When cnt reaches len: o_adder = final acc, o_adder_valid=1, go to IDLE, cnt=0.
  - ACC, non-110 valid beat arriving:
    - Partial acc is dropped; o_err set (sticky until rst); go to IDLE.
    - The beat itself is processed normally in the same cycle.
  - ACC, bubbles: no effect.
  - Accumulator wraps mod 2^DATA_TYPE; no saturation.
- i_acc_len is ignored on non-first 110 beats.

Decomposition:
- Package edge_sw_pkg holds:
  - command constants: CMD_IDLE0/1, CMD_ADD, CMD_VN_L, CMD_VN_R, CMD_VN_LR, CMD_ACC, CMD_RSVD
  - FSM state encoding: IDLE, ACC
- Sub-module edge_pipe_adder: ADD_LAT-stage registered integer adder (DATA_TYPE, ADD_LAT params; CLK, rst, A, B, O).
- The top module holds the mux, the delay line and the FSM.

Test Plan:
(Defaults, LAT=3.)
- Add: lanes {3:40, 2:30, 1:20, 0:10}, i_sel=1, cmd 010, one beat at edge 0 -> edge 3: o_adder=50, o_adder_valid=1 for one cycle. Idle at edges 1,2,4.
- Forward/VN: same bus with cmd 011 then 100 then 101 back-to-back at edges 0-2:
  - edge 3: o_adder=30, o_vn low=10, valid 01
  - edge 4: o_adder=20, o_vn high=40, valid 10
  - edge 5: o_vn={30,20}, valid 11, o_adder_valid=0
- Accumulate: i_acc_len=3, three 110 beats with sums 5, 7, 0xFFFF (i_sel=0) -> single strobe at edge 5 (last beat+3) with o_adder=0x000B (wrap). No strobes before it.
- acc_len 0/1: 110 beat with len=0, sum 9 -> o_adder=9 strobe after LAT, FSM stays IDLE.
- Abort: len=4, two 110 beats then 010 (sum 50) -> o_err=1, o_adder=50 strobed at the 010 beat's edge+3, no accumulate strobe. o_err stays 1 until rst.
- Reset mid-pipe: add beat at edge 0, rst high at edge 1 -> all outputs 0, no strobe at edge 3. Next beat after rst releases behaves normally.

Source files
------------

// File: rtl/edge_sw_pkg.sv
// Shared command encodings and FSM state type for the edge adder switch.
package edge_sw_pkg;

    localparam logic [2:0] CMD_IDLE0 = 3'b000;
    localparam logic [2:0] CMD_IDLE1 = 3'b001;
    localparam logic [2:0] CMD_ADD   = 3'b010;
    localparam logic [2:0] CMD_VN_L  = 3'b011;
    localparam logic [2:0] CMD_VN_R  = 3'b100;
    localparam logic [2:0] CMD_VN_LR = 3'b101;
    localparam logic [2:0] CMD_ACC   = 3'b110;
    localparam logic [2:0] CMD_RSVD  = 3'b111;

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_t;

endpackage

// File: rtl/edge_pipe_adder.sv
// Registered integer adder with ADD_LAT pipeline stages; the sum is computed in the first stage.
module edge_pipe_adder #(
    parameter int DATA_TYPE = 16,
    parameter int ADD_LAT   = 2
) (
    input  logic                 CLK,
    input  logic                 rst,
    input  logic [DATA_TYPE-1:0] A,
    input  logic [DATA_TYPE-1:0] B,
    output logic [DATA_TYPE-1:0] O
);

    genvar gi;
    generate
        for (gi = 0; gi < ADD_LAT; gi++) begin : g_stage
            logic [DATA_TYPE-1:0] q;
            if (gi == 0) begin : g_first
                always_ff @(posedge CLK) begin
                    if (rst) q <= '0;
                    else     q <= A + B;
                end
            end else begin : g_next
                always_ff @(posedge CLK) begin
                    if (rst) q <= '0;
                    else     q <= g_stage[gi-1].q;
                end
            end
        end
    endgenerate

    assign O = g_stage[ADD_LAT-1].q;

endmodule

// File: rtl/edge_adder_switch_acc.sv
// Successor edge adder switch: pair mux, delay-matched command pipe and multi-beat accumulate FSM.
module edge_adder_switch_acc
    import edge_sw_pkg::*;
#(
    parameter int DATA_TYPE = 16,
    parameter int NUM_IN    = 4,
    parameter int SEL_IN    = 2,
    parameter int ADD_LAT   = 2,
    parameter int CNT_W     = 8
) (
    input  logic                        CLK,
    input  logic                        rst,
    input  logic                        i_valid,
    input  logic [DATA_TYPE*NUM_IN-1:0] i_data_bus,
    input  logic [2:0]                  i_cmd,
    input  logic [SEL_IN-1:0]           i_sel,
    input  logic [CNT_W-1:0]            i_acc_len,
    output logic [DATA_TYPE-1:0]        o_adder,
    output logic                        o_adder_valid,
    output logic [2*DATA_TYPE-1:0]      o_vn,
    output logic [1:0]                  o_vn_valid,
    output logic                        o_err
);

    localparam int MAX_SEL = NUM_IN - 2;

    typedef struct packed {
        logic                 valid;
        logic [2:0]           cmd;
        logic [DATA_TYPE-1:0] a;
        logic [DATA_TYPE-1:0] b;
        logic [DATA_TYPE-1:0] l0;
        logic [DATA_TYPE-1:0] ln;
        logic [CNT_W-1:0]     len;
    } side_t;

    logic [DATA_TYPE-1:0] a_mux, b_mux;
    side_t                s0_reg, tail;
    logic [DATA_TYPE-1:0] tail_sum;

    // Out-of-range selects clamp to the topmost lane pair.
    always_comb begin
        int sel_int;
        sel_int = (int'(i_sel) > MAX_SEL) ? MAX_SEL : int'(i_sel);
        a_mux   = i_data_bus[DATA_TYPE +: DATA_TYPE];
        b_mux   = i_data_bus[0 +: DATA_TYPE];
        for (int n = 0; n <= MAX_SEL; n++) begin
            if (n == sel_int) begin
                a_mux = i_data_bus[(n+1)*DATA_TYPE +: DATA_TYPE];
                b_mux = i_data_bus[n*DATA_TYPE +: DATA_TYPE];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            s0_reg <= '0;
        end else begin
            s0_reg.valid <= i_valid;
            s0_reg.cmd   <= i_cmd;
            s0_reg.a     <= a_mux;
            s0_reg.b     <= b_mux;
            s0_reg.l0    <= i_data_bus[0 +: DATA_TYPE];
            s0_reg.ln    <= i_data_bus[(NUM_IN-1)*DATA_TYPE +: DATA_TYPE];
            s0_reg.len   <= i_acc_len;
        end
    end

    edge_pipe_adder #(.DATA_TYPE(DATA_TYPE), .ADD_LAT(ADD_LAT)) u_add (
        .CLK (CLK),
        .rst (rst),
        .A   (s0_reg.a),
        .B   (s0_reg.b),
        .O   (tail_sum)
    );

    // Side-band delay line, one stage per adder stage so tail lines up with tail_sum.
    genvar gi;
    generate
        for (gi = 0; gi < ADD_LAT; gi++) begin : g_dly
            side_t q;
            if (gi == 0) begin : g_first
                always_ff @(posedge CLK) begin
                    if (rst) q <= '0;
                    else     q <= s0_reg;
                end
            end else begin : g_next
                always_ff @(posedge CLK) begin
                    if (rst) q <= '0;
                    else     q <= g_dly[gi-1].q;
                end
            end
        end
    endgenerate

    assign tail = g_dly[ADD_LAT-1].q;

    state_t                 state_reg, state_next;
    logic [CNT_W-1:0]       cnt_reg, cnt_next, len_reg, len_next, first_len;
    logic [DATA_TYPE-1:0]   acc_reg, acc_next, acc_sum;
    logic [DATA_TYPE-1:0]   adder_reg, adder_next;
    logic                   adder_valid_reg, adder_valid_next;
    logic [2*DATA_TYPE-1:0] vn_reg, vn_next;
    logic [1:0]             vn_valid_reg, vn_valid_next;
    logic                   err_reg, err_next;

    always_comb begin
        state_next       = state_reg;
        cnt_next         = cnt_reg;
        len_next         = len_reg;
        acc_next         = acc_reg;
        adder_next       = adder_reg;
        adder_valid_next = 1'b0;
        vn_next          = vn_reg;
        vn_valid_next    = 2'b00;
        err_next         = err_reg;
        first_len        = (tail.len == '0) ? CNT_W'(1) : tail.len;
        acc_sum          = acc_reg + tail_sum;

        if (tail.valid) begin
            // A foreign beat mid-accumulation aborts it, then is handled like any other beat.
            if (state_reg == ACC && tail.cmd != CMD_ACC) begin
                err_next   = 1'b1;
                state_next = IDLE;
                cnt_next   = '0;
            end
            case (tail.cmd)
                CMD_ADD: begin
                    adder_next       = tail_sum;
                    adder_valid_next = 1'b1;
                end
                CMD_VN_L: begin
                    vn_next[DATA_TYPE-1:0] = tail.l0;
                    vn_valid_next          = 2'b01;
                    adder_next             = tail.a;
                    adder_valid_next       = 1'b1;
                end
                CMD_VN_R: begin
                    vn_next[2*DATA_TYPE-1:DATA_TYPE] = tail.ln;
                    vn_valid_next                    = 2'b10;
                    adder_next                       = tail.b;
                    adder_valid_next                 = 1'b1;
                end
                CMD_VN_LR: begin
                    vn_next       = {tail.a, tail.b};
                    vn_valid_next = 2'b11;
                end
                CMD_ACC: begin
                    if (state_reg == IDLE) begin
                        if (first_len == CNT_W'(1)) begin
                            adder_next       = tail_sum;
                            adder_valid_next = 1'b1;
                        end else begin
                            acc_next   = tail_sum;
                            cnt_next   = CNT_W'(1);
                            len_next   = first_len;
                            state_next = ACC;
                        end
                    end else if (cnt_reg + CNT_W'(1) == len_reg) begin
                        adder_next       = acc_sum;
                        adder_valid_next = 1'b1;
                        cnt_next         = '0;
                        state_next       = IDLE;
                    end else begin
                        acc_next = acc_sum;
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            state_reg       <= IDLE;
            cnt_reg         <= '0;
            len_reg         <= '0;
            acc_reg         <= '0;
            adder_reg       <= '0;
            adder_valid_reg <= 1'b0;
            vn_reg          <= '0;
            vn_valid_reg    <= 2'b00;
            err_reg         <= 1'b0;
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            len_reg         <= len_next;
            acc_reg         <= acc_next;
            adder_reg       <= adder_next;
            adder_valid_reg <= adder_valid_next;
            vn_reg          <= vn_next;
            vn_valid_reg    <= vn_valid_next;
            err_reg         <= err_next;
        end
    end

    assign o_adder       = adder_reg;
    assign o_adder_valid = adder_valid_reg;
    assign o_vn          = vn_reg;
    assign o_vn_valid    = vn_valid_reg;
    assign o_err         = err_reg;

endmodule

// File: tb/tb_edge_adder_switch_acc.sv
// Directed bench for edge_adder_switch_acc at default parameters (latency 3).
module tb_edge_adder_switch_acc;

    localparam int DT = 16;
    localparam int NI = 4;
    localparam int SW = 2;
    localparam int AL = 2;
    localparam int CW = 8;

    logic           CLK = 1'b0;
    logic           rst;
    logic           i_valid;
    logic [DT*NI-1:0] i_data_bus;
    logic [2:0]     i_cmd;
    logic [SW-1:0]  i_sel;
    logic [CW-1:0]  i_acc_len;
    logic [DT-1:0]  o_adder;
    logic           o_adder_valid;
    logic [2*DT-1:0] o_vn;
    logic [1:0]     o_vn_valid;
    logic           o_err;

    int n_pass  = 0;
    int n_total = 0;

    localparam logic [63:0] STD_BUS = {16'd40, 16'd30, 16'd20, 16'd10};

    edge_adder_switch_acc #(
        .DATA_TYPE(DT), .NUM_IN(NI), .SEL_IN(SW), .ADD_LAT(AL), .CNT_W(CW)
    ) dut (
        .CLK           (CLK),
        .rst           (rst),
        .i_valid       (i_valid),
        .i_data_bus    (i_data_bus),
        .i_cmd         (i_cmd),
        .i_sel         (i_sel),
        .i_acc_len     (i_acc_len),
        .o_adder       (o_adder),
        .o_adder_valid (o_adder_valid),
        .o_vn          (o_vn),
        .o_vn_valid    (o_vn_valid),
        .o_err         (o_err)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        $display("check %-14s observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic beat(input logic [2:0] cmd, input logic [SW-1:0] sel,
                        input logic [CW-1:0] len, input logic [63:0] bus);
        i_valid    = 1'b1;
        i_cmd      = cmd;
        i_sel      = sel;
        i_acc_len  = len;
        i_data_bus = bus;
    endtask

    task automatic bubble();
        i_valid = 1'b0;
        i_cmd   = 3'b000;
    endtask

    initial begin
        rst = 1'b1; i_valid = 1'b0; i_cmd = 3'b000; i_sel = '0; i_acc_len = '0; i_data_bus = '0;
        tick(); tick();
        chk("rst_adder",  32'(o_adder), 32'h0);
        chk("rst_avalid", 32'(o_adder_valid), 32'h0);
        chk("rst_vn",     o_vn, 32'h0);
        chk("rst_vvalid", 32'(o_vn_valid), 32'h0);
        chk("rst_err",    32'(o_err), 32'h0);
        rst = 1'b0;

        // add: 30+20
        beat(3'b010, 2'd1, 8'd0, STD_BUS); tick(); bubble();
        tick(); chk("add_e1_valid", 32'(o_adder_valid), 32'h0);
        tick(); chk("add_e2_valid", 32'(o_adder_valid), 32'h0);
        tick(); chk("add_e3_sum",   32'(o_adder), 32'd50);
                chk("add_e3_valid", 32'(o_adder_valid), 32'h1);
        tick(); chk("add_e4_valid", 32'(o_adder_valid), 32'h0);
                chk("add_e4_hold",  32'(o_adder), 32'd50);

        // forward / VN back-to-back
        beat(3'b011, 2'd1, 8'd0, STD_BUS); tick();
        beat(3'b100, 2'd1, 8'd0, STD_BUS); tick();
        beat(3'b101, 2'd1, 8'd0, STD_BUS); tick(); bubble();
        tick(); chk("vnl_adder",  32'(o_adder), 32'd30);
                chk("vnl_avalid", 32'(o_adder_valid), 32'h1);
                chk("vnl_vn",     o_vn, 32'h0000_000A);
                chk("vnl_vvalid", 32'(o_vn_valid), 32'h1);
        tick(); chk("vnr_adder",  32'(o_adder), 32'd20);
                chk("vnr_avalid", 32'(o_adder_valid), 32'h1);
                chk("vnr_vn",     o_vn, 32'h0028_000A);
                chk("vnr_vvalid", 32'(o_vn_valid), 32'h2);
        tick(); chk("vnlr_vn",     o_vn, 32'h001E_0014);
                chk("vnlr_vvalid", 32'(o_vn_valid), 32'h3);
                chk("vnlr_avalid", 32'(o_adder_valid), 32'h0);
        tick(); chk("vn_idle_vvalid", 32'(o_vn_valid), 32'h0);

        // accumulate 5 + 7 + 0xFFFF over three beats; len on later beats ignored
        beat(3'b110, 2'd0, 8'd3, {16'd0, 16'd0, 16'd2, 16'd3}); tick();
        beat(3'b110, 2'd0, 8'd7, {16'd0, 16'd0, 16'd4, 16'd3}); tick();
        beat(3'b110, 2'd0, 8'd1, {16'd0, 16'd0, 16'hFFFE, 16'd1}); tick(); bubble();
        tick(); chk("acc_e3_valid", 32'(o_adder_valid), 32'h0);
        tick(); chk("acc_e4_valid", 32'(o_adder_valid), 32'h0);
        tick(); chk("acc_e5_sum",   32'(o_adder), 32'h000B);
                chk("acc_e5_valid", 32'(o_adder_valid), 32'h1);
        tick(); chk("acc_e6_valid", 32'(o_adder_valid), 32'h0);
                chk("acc_err",      32'(o_err), 32'h0);

        // len 0 acts as len 1; a following add must not look like an abort
        beat(3'b110, 2'd0, 8'd0, {16'd0, 16'd0, 16'd4, 16'd5}); tick();
        beat(3'b010, 2'd1, 8'd0, STD_BUS); tick(); bubble();
        tick(); chk("len0_e2_valid", 32'(o_adder_valid), 32'h0);
        tick(); chk("len0_sum",      32'(o_adder), 32'd9);
                chk("len0_valid",    32'(o_adder_valid), 32'h1);
        tick(); chk("len0_add_sum",  32'(o_adder), 32'd50);
                chk("len0_add_valid", 32'(o_adder_valid), 32'h1);
                chk("len0_err",      32'(o_err), 32'h0);

        // abort: len 4, two acc beats, then an add
        beat(3'b110, 2'd0, 8'd4, {16'd0, 16'd0, 16'd2, 16'd3}); tick();
        beat(3'b110, 2'd0, 8'd4, {16'd0, 16'd0, 16'd2, 16'd3}); tick();
        beat(3'b010, 2'd1, 8'd0, STD_BUS); tick(); bubble();
        tick(); chk("abt_e3_valid", 32'(o_adder_valid), 32'h0);
                chk("abt_e3_err",   32'(o_err), 32'h0);
        tick(); chk("abt_e4_valid", 32'(o_adder_valid), 32'h0);
        tick(); chk("abt_sum",      32'(o_adder), 32'd50);
                chk("abt_valid",    32'(o_adder_valid), 32'h1);
                chk("abt_err",      32'(o_err), 32'h1);
        tick(); chk("abt_e6_valid", 32'(o_adder_valid), 32'h0);
        tick(); tick(); tick();
        chk("abt_err_sticky", 32'(o_err), 32'h1);

        // reset mid-pipe discards the in-flight beat
        beat(3'b010, 2'd0, 8'd0, STD_BUS); tick(); bubble();
        rst = 1'b1; tick();
        chk("mrst_adder",  32'(o_adder), 32'h0);
        chk("mrst_vn",     o_vn, 32'h0);
        chk("mrst_err",    32'(o_err), 32'h0);
        chk("mrst_avalid", 32'(o_adder_valid), 32'h0);
        rst = 1'b0;
        tick(); tick();
        chk("mrst_e3_valid", 32'(o_adder_valid), 32'h0);
        chk("mrst_e3_adder", 32'(o_adder), 32'h0);

        // post-reset beat, sel=3 clamps to lanes 3/2
        beat(3'b010, 2'd3, 8'd0, STD_BUS); tick(); bubble();
        tick(); tick();
        chk("post_e2_valid", 32'(o_adder_valid), 32'h0);
        tick();
        chk("post_sum",   32'(o_adder), 32'd70);
        chk("post_valid", 32'(o_adder_valid), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
